// File: rtl/tag_bits_loader.sv
// tag_bits_loader
//
// Collects a host-supplied scan frame of NUM_WORDS words into a shadow register.
// A hop_rst pulse swaps the shadow into the active tx_bits word, but only once a
// complete frame is ready. Malformed frames are dropped and flagged.
// If a frame is too long, the rest of that frame is discarded up to its tlast.
//
// Optional feature (macro TAG_BITS_LOADER_CRC_EN): after a frame completes, a
// serial CRC-8 (poly 0x07, init 0) is computed over shadow bits [NTX_BITS-9:0],
// LSB first, and written into shadow bits [NTX_BITS-1:NTX_BITS-8].
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   s_tdata/s_tvalid/
//   s_tready/s_tlast    - host word stream (accepted on s_tvalid && s_tready)
//   hop_rst             - hop boundary pulse; requests shadow -> tx_bits swap
//   tx_bits             - active scan word
//   bits_valid          - tx_bits holds at least one host-loaded frame
//   frame_err           - one-cycle pulse per dropped frame
//   underrun_cnt        - saturating count of hop_rst with no frame ready
//   hop_cnt             - wrapping count of successful swaps
module tag_bits_loader #(
    parameter int unsigned TX_BITS_WIDTH = 128,
    parameter int unsigned NTX_BITS      = 78,
    parameter int unsigned WORD_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WORD_WIDTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    input  logic                     hop_rst,
    output logic [TX_BITS_WIDTH-1:0] tx_bits,
    output logic                     bits_valid,
    output logic                     frame_err,
    output logic [15:0]              underrun_cnt,
    output logic [15:0]              hop_cnt
);

    localparam int unsigned NUM_WORDS = (NTX_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned KW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [KW-1:0] KLast   = KW'(NUM_WORDS - 1);
    // Bits at or above NTX_BITS are never meaningful and are kept at zero.
    localparam logic [TX_BITS_WIDTH-1:0] NtxMask =
        {TX_BITS_WIDTH{1'b1}} >> (TX_BITS_WIDTH - NTX_BITS);

`ifdef TAG_BITS_LOADER_CRC_EN
    localparam int unsigned IW = $clog2(NTX_BITS);
    localparam logic [IW-1:0] IdxLast = IW'(NTX_BITS - 9);
    typedef enum logic [1:0] {StFill, StCrc, StReady} state_e;
`else
    typedef enum logic [0:0] {StFill, StReady} state_e;
`endif

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     discard_q, discard_d;
    logic [TX_BITS_WIDTH-1:0] shadow_q, shadow_d;
    logic [TX_BITS_WIDTH-1:0] tx_q, tx_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [15:0]              under_q, under_d;
    logic [15:0]              hop_q, hop_d;

    logic                     accept;
    logic [TX_BITS_WIDTH-1:0] word_shift;
    logic [TX_BITS_WIDTH-1:0] word_mask;

`ifdef TAG_BITS_LOADER_CRC_EN
    logic [7:0]    crc_q, crc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          crc_fb;
    logic [7:0]    crc_next;
`endif

    assign s_tready     = (state_q == StFill);
    assign accept       = s_tvalid && s_tready;
    assign tx_bits      = tx_q;
    assign bits_valid   = valid_q;
    assign frame_err    = err_q;
    assign underrun_cnt = under_q;
    assign hop_cnt      = hop_q;

    // Place the incoming word at slot k of the shadow register.
    assign word_shift = TX_BITS_WIDTH'(s_tdata) << (k_q * WORD_WIDTH);
    assign word_mask  = TX_BITS_WIDTH'({WORD_WIDTH{1'b1}}) << (k_q * WORD_WIDTH);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        discard_d = discard_q;
        shadow_d  = shadow_q;
        tx_d      = tx_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        under_d   = under_q;
        hop_d     = hop_q;
`ifdef TAG_BITS_LOADER_CRC_EN
        crc_d     = crc_q;
        idx_d     = idx_q;
        crc_fb    = crc_q[7] ^ shadow_q[idx_q];
        crc_next  = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif

        // Hop handling uses the current state, so a hop coincident with the
        // final word still counts as an underrun.
        if (hop_rst) begin
            if (state_q == StReady) begin
                tx_d    = shadow_q;
                valid_d = 1'b1;
                hop_d   = hop_q + 16'd1;
            end else if (under_q != 16'hFFFF) begin
                under_d = under_q + 16'd1;
            end
        end

        case (state_q)
            StFill: begin
                if (accept) begin
                    if (discard_q) begin
                        if (s_tlast) begin
                            discard_d = 1'b0;
                            k_d       = '0;
                        end
                    end else begin
                        shadow_d = (shadow_q & ~word_mask) | (word_shift & word_mask & NtxMask);
                        if (k_q == KLast) begin
                            k_d = '0;
                            if (s_tlast) begin
`ifdef TAG_BITS_LOADER_CRC_EN
                                state_d = StCrc;
                                crc_d   = 8'h00;
                                idx_d   = '0;
`else
                                state_d = StReady;
`endif
                            end else begin
                                // Frame too long: drop it and swallow words to tlast.
                                err_d     = 1'b1;
                                discard_d = 1'b1;
                            end
                        end else if (s_tlast) begin
                            err_d = 1'b1;
                            k_d   = '0;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
            end
`ifdef TAG_BITS_LOADER_CRC_EN
            StCrc: begin
                crc_d = crc_next;
                if (idx_q == IdxLast) begin
                    shadow_d[NTX_BITS-1 -: 8] = crc_next;
                    state_d                   = StReady;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
`endif
            StReady: begin
                if (hop_rst) begin
                    state_d = StFill;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFill;
            k_q       <= '0;
            discard_q <= 1'b0;
            shadow_q  <= '0;
            tx_q      <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            under_q   <= '0;
            hop_q     <= '0;
`ifdef TAG_BITS_LOADER_CRC_EN
            crc_q     <= '0;
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            discard_q <= discard_d;
            shadow_q  <= shadow_d;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            under_q   <= under_d;
            hop_q     <= hop_d;
`ifdef TAG_BITS_LOADER_CRC_EN
            crc_q     <= crc_d;
            idx_q     <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_tag_bits_loader.sv
// Testbench for tag_bits_loader: directed cases plus randomized frame traffic,
// checked against a frame-level reference model.
module tb_tag_bits_loader;

    localparam int unsigned TXW     = 128;
    localparam int unsigned NTX     = 78;
    localparam int unsigned WW      = 32;
    localparam int unsigned NW      = 3;
    localparam int unsigned CRC_CYC = NTX - 8;

    logic           clk;
    logic           reset;
    logic [WW-1:0]  s_tdata;
    logic           s_tvalid;
    logic           s_tready;
    logic           s_tlast;
    logic           hop_rst;
    logic [TXW-1:0] tx_bits;
    logic           bits_valid;
    logic           frame_err;
    logic [15:0]    underrun_cnt;
    logic [15:0]    hop_cnt;

    tag_bits_loader #(
        .TX_BITS_WIDTH (TXW),
        .NTX_BITS      (NTX),
        .WORD_WIDTH    (WW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .hop_rst      (hop_rst),
        .tx_bits      (tx_bits),
        .bits_valid   (bits_valid),
        .frame_err    (frame_err),
        .underrun_cnt (underrun_cnt),
        .hop_cnt      (hop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
    end

    // Reference model state (frame level).
    logic [TXW-1:0] m_tx, m_shadow;
    bit             m_valid, m_ready, m_disc;
    int             m_hop, m_under, m_err, m_k;
    logic [WW-1:0]  m_words [NW];
`ifdef TAG_BITS_LOADER_CRC_EN
    bit             early_hop_req = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // CRC-8, poly 0x07, init 0, message bits 0..NTX-9 taken LSB first.
    function automatic logic [7:0] crc8(input logic [TXW-1:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i <= int'(NTX) - 9; i++) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [TXW-1:0] build_frame();
        logic [TXW-1:0] f;
        f = '0;
        for (int w = 0; w < int'(NW); w++) begin
            for (int b = 0; b < int'(WW); b++) begin
                if (w * int'(WW) + b < int'(NTX)) f[w * int'(WW) + b] = m_words[w][b];
            end
        end
`ifdef TAG_BITS_LOADER_CRC_EN
        f[NTX-1 -: 8] = crc8(f);
`endif
        return f;
    endfunction

    task automatic model_reset();
        m_tx = '0; m_shadow = '0; m_valid = 0; m_ready = 0; m_disc = 0;
        m_hop = 0; m_under = 0; m_k = 0;
    endtask

    task automatic model_hop();
        if (m_ready) begin
            m_tx = m_shadow; m_valid = 1; m_hop++; m_ready = 0; m_k = 0;
        end else if (m_under < 65535) begin
            m_under++;
        end
    endtask

    task automatic model_word(input logic [WW-1:0] d, input bit last, output bit done);
        done = 0;
        if (m_disc) begin
            if (last) begin m_disc = 0; m_k = 0; end
        end else begin
            m_words[m_k] = d;
            if (m_k == int'(NW) - 1) begin
                m_k = 0;
                if (last) begin
                    done     = 1;
                    m_shadow = build_frame();
`ifndef TAG_BITS_LOADER_CRC_EN
                    m_ready  = 1;
`endif
                end else begin
                    m_err++; m_disc = 1;
                end
            end else if (last) begin
                m_err++; m_k = 0;
            end else begin
                m_k++;
            end
        end
    endtask

`ifdef TAG_BITS_LOADER_CRC_EN
    // Called at the negedge right after the final word was accepted.
    task automatic crc_wait();
        int low;
        low = 0;
        for (int i = 0; i < int'(CRC_CYC); i++) begin
            if (!s_tready) low++;
            if (early_hop_req && i == int'(CRC_CYC) - 1) begin
                hop_rst = 1'b1;
                model_hop();
            end
            @(negedge clk);
            hop_rst = 1'b0;
        end
        early_hop_req = 1'b0;
        m_ready = 1;
        check_eq("crc_busy", 128'(low), 128'(CRC_CYC));
    endtask
`endif

    task automatic xfer(input logic [WW-1:0] d, input bit last, input bit hop);
        int n;
        bit done;
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1; hop_rst = hop;
        n = 0;
        while (s_tready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (s_tready !== 1'b1) begin
            check_eq("tready_timeout", 128'(s_tready), 128'(1));
            s_tvalid = 1'b0; hop_rst = 1'b0; s_tlast = 1'b0;
            return;
        end
        if (hop) model_hop();
        model_word(d, last, done);
        @(negedge clk);
        s_tvalid = 1'b0; hop_rst = 1'b0; s_tlast = 1'b0;
`ifdef TAG_BITS_LOADER_CRC_EN
        if (done) crc_wait();
`endif
    endtask

    task automatic hop_pulse();
        hop_rst = 1'b1;
        model_hop();
        @(negedge clk);
        hop_rst = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; s_tvalid = 1'b0; hop_rst = 1'b0; s_tlast = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        #1;
        check_eq({tag, ".tx"},     tx_bits, m_tx);
        check_eq({tag, ".valid"},  128'(bits_valid), 128'(m_valid));
        check_eq({tag, ".hop"},    128'(hop_cnt), 128'(16'(m_hop)));
        check_eq({tag, ".under"},  128'(underrun_cnt), 128'(16'(m_under)));
        check_eq({tag, ".err"},    128'(err_seen), 128'(m_err));
        check_eq({tag, ".tready"}, 128'(s_tready), 128'(!m_ready));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TXW-1:0] golden;
        int op, kk, nj;
        m_err = 0;
        s_tdata = '0;
        do_reset();
        check_all("reset");

        // Underruns with nothing loaded.
        repeat (3) hop_pulse();
        check_all("underrun3");

        // Basic frame and swap.
        xfer(32'h11111111, 0, 0);
        xfer(32'h22222222, 0, 0);
        xfer(32'h00003FFF, 1, 0);
        hop_pulse();
        check_all("basic");
`ifndef TAG_BITS_LOADER_CRC_EN
        golden = {50'b0, 14'h3FFF, 32'h22222222, 32'h11111111};
        check_eq("basic_literal", tx_bits, golden);
`endif

        // Short frame then a good one.
        xfer(32'hAAAA0001, 0, 0);
        xfer(32'hAAAA0002, 1, 0);
        check_all("short");
        xfer(32'h01234567, 0, 0);
        xfer(32'h89ABCDEF, 0, 0);
        xfer(32'hFFFFFFFF, 1, 0);
        hop_pulse();
        check_all("short_next");

        // Long frame, discarded junk, then a good frame.
        xfer(32'hDEAD0000, 0, 0);
        xfer(32'hDEAD0001, 0, 0);
        xfer(32'hDEAD0002, 0, 0);
        xfer(32'hBAD00000, 0, 0);
        xfer(32'hBAD00001, 1, 0);
        check_all("long");
        xfer(32'h13579BDF, 0, 0);
        xfer(32'h2468ACE0, 0, 0);
        xfer(32'h00001234, 1, 0);
        hop_pulse();
        check_all("long_next");

        // Hop coincident with the final word.
        xfer(32'h0F0F0F0F, 0, 0);
        xfer(32'hF0F0F0F0, 0, 0);
        xfer(32'h00000A5A, 1, 1);
        check_all("coincident");
        hop_pulse();
        check_all("coincident_swap");

`ifdef TAG_BITS_LOADER_CRC_EN
        // All-zero payload; a hop on the last CRC cycle must still underrun.
        xfer(32'h0, 0, 0);
        xfer(32'h0, 0, 0);
        early_hop_req = 1'b1;
        xfer(32'h0, 1, 0);
        check_all("crc_zero_early");
        hop_pulse();
        check_all("crc_zero");
        check_eq("crc_zero_field", 128'(tx_bits[NTX-1 -: 8]), 128'(8'h00));
        xfer(32'h1, 0, 0);
        xfer(32'h0, 0, 0);
        xfer(32'h0, 1, 0);
        hop_pulse();
        check_all("crc_bit0");
        golden = '0;
        golden[0] = 1'b1;
        check_eq("crc_bit0_field", 128'(tx_bits[NTX-1 -: 8]), 128'(crc8(golden)));
`endif

        // Reset mid-frame abandons the frame silently.
        xfer(32'h77777777, 0, 0);
        xfer(32'h66666666, 0, 0);
        do_reset();
        check_all("reset_mid");

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if (m_ready) begin
                hop_pulse();
                check_all("rnd_swap");
                continue;
            end
            op = int'($urandom_range(0, 4));
            case (op)
                0, 4: begin
                    for (int w = 0; w < int'(NW); w++) begin
                        if (w == int'(NW) - 1) xfer($urandom(), 1, op == 4);
                        else xfer($urandom(), 0, $urandom_range(0, 3) == 0);
                    end
                end
                1: begin
                    kk = int'($urandom_range(0, NW - 2));
                    for (int w = 0; w <= kk; w++) xfer($urandom(), w == kk, 0);
                end
                2: begin
                    for (int w = 0; w < int'(NW); w++) xfer($urandom(), 0, 0);
                    nj = int'($urandom_range(0, 2));
                    repeat (nj) xfer($urandom(), 0, 0);
                    xfer($urandom(), 1, 0);
                end
                default: hop_pulse();
            endcase
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
